// File: rtl/aco_frame_packer.sv
// aco_frame_packer: packs per-frame quantizer coefficients into vectors, buffers them in a small FIFO
module aco_frame_packer #(
  parameter int BW       = 8,
  parameter int NUM_COEF = 13,
  parameter int DEPTH    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [BW-1:0]          data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic [NUM_COEF*BW-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   ovf_o,
  output logic                   err_o
);
  localparam int CW = $clog2(NUM_COEF);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = NUM_COEF * BW;
  typedef enum logic {COLLECT, DROP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] lane [NUM_COEF-1];
  logic [VW-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_nxt;
  logic [AW:0] count, count_nxt;
  logic [VW-1:0] vec;
  logic beat, collect, at_end, push, pop, full, accept, bad_len;
  always_comb begin
    vec = {data_i, {(VW-BW){1'b0}}};
    for (int k = 0; k < NUM_COEF-1; k++) vec[k*BW +: BW] = lane[k];
  end
  assign beat      = valid_i & en_i;
  assign collect   = state == COLLECT;
  assign at_end    = cnt == CW'(NUM_COEF-1);
  assign push      = beat & collect & last_i & at_end;
  assign bad_len   = beat & collect & (last_i ^ at_end);
  assign pop       = valid_o & ready_i;
  assign full      = count == (AW+1)'(DEPTH);
  assign accept    = push & (!full | pop);
  assign rd_nxt    = rd + 1'b1;
  assign count_nxt = count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
  assign valid_o   = |count;
  // Storage needs no reset: cnt and count gate every read of it.
  always_ff @(posedge clk_i) begin
    if (beat && collect && !at_end) lane[cnt] <= data_i;
    if (accept) mem[wr] <= vec;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= COLLECT;
      cnt    <= '0;
      rd     <= '0;
      wr     <= '0;
      count  <= '0;
      data_o <= '0;
      ovf_o  <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (beat) begin
        if (!collect) begin
          if (last_i) begin
            state <= COLLECT;
            cnt   <= '0;
          end
        end else if (last_i || at_end) begin
          cnt <= '0;
          if (!last_i) state <= DROP;
        end else cnt <= cnt + 1'b1;
      end
      err_o <= bad_len ? 1'b1 : clr_i ? 1'b0 : err_o;
      ovf_o <= (push & full & !pop) ? 1'b1 : clr_i ? 1'b0 : ovf_o;
      if (accept) wr <= wr + 1'b1;
      if (pop) rd <= rd_nxt;
      count <= count_nxt;
      // data_o mirrors the head entry and holds its value once the FIFO empties
      if (pop && count > 1) data_o <= mem[rd_nxt];
      else if (accept && (count == 0 || (pop && count == 1))) data_o <= vec;
    end
  end
endmodule

// File: tb/tb_aco_frame_packer.sv
// tb_aco_frame_packer: directed frames, scoreboard queue of expected vectors, decoupled pop monitor
module tb_aco_frame_packer;
  logic clk = 0, rst_n = 0, en = 1, clr = 0, valid = 0, last = 0, ready = 1;
  logic [7:0] data = 0;
  logic [103:0] data_o;
  logic valid_o, ovf_o, err_o;
  logic [103:0] q[$];
  logic [103:0] expv;
  int total = 0, bad = 0;
  aco_frame_packer dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .data_i(data),
    .valid_i(valid), .last_i(last), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready), .ovf_o(ovf_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  function automatic logic [103:0] mk(input logic [7:0] start, input logic [7:0] step);
    logic [103:0] v;
    v = '0;
    for (int k = 0; k < 13; k++) v[k*8 +: 8] = start + 8'(k) * step;
    return v;
  endfunction
  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic frame(input int n, input int last_at, input logic [7:0] start,
                       input logic [7:0] step, input logic rdy_final);
    for (int k = 0; k < n; k++) begin
      valid = 1;
      data  = start + 8'(k) * step;
      last  = (k == last_at - 1);
      if (rdy_final && k == n - 1) ready = 1;
      @(posedge clk); #1;
    end
    valid = 0;
    last  = 0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || valid_o); i++) tick();
    chk("drain_left", 104'(q.size()), 104'(0));
    chk("drain_valid", 104'(valid_o), 104'(0));
  endtask
  task automatic clear();
    clr = 1;
    tick();
    clr = 0;
  endtask
  always @(negedge clk) begin
    if (rst_n && valid_o && ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop: unexpected vector %h", data_o);
      end else begin
        expv = q.pop_front();
        if (data_o !== expv) begin
          bad++;
          $display("FAIL pop: got %h expected %h", data_o, expv);
        end
      end
    end
  end
  initial begin
    #12;
    chk("rst_valid", 104'(valid_o), 104'(0));
    chk("rst_data", data_o, 104'(0));
    chk("rst_ovf", 104'(ovf_o), 104'(0));
    chk("rst_err", 104'(err_o), 104'(0));
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    // 1: basic frame 1..13
    q.push_back(mk(8'd1, 8'd1));
    frame(13, 13, 8'd1, 8'd1, 0);
    chk("t1_valid", 104'(valid_o), 104'(1));
    chk("t1_lane0", 104'(data_o[7:0]), 104'(1));
    chk("t1_lane12", 104'(data_o[103:96]), 104'(13));
    drain();
    // 2: overflow with consumer stalled
    ready = 0;
    q.push_back(mk(8'h10, 8'd1));
    q.push_back(mk(8'h20, 8'd1));
    frame(13, 13, 8'h10, 8'd1, 0);
    frame(13, 13, 8'h20, 8'd1, 0);
    frame(13, 13, 8'h30, 8'd1, 0);
    chk("t2_ovf", 104'(ovf_o), 104'(1));
    chk("t2_valid", 104'(valid_o), 104'(1));
    chk("t2_head", data_o, mk(8'h10, 8'd1));
    tick(); tick();
    chk("t2_hold", data_o, mk(8'h10, 8'd1));
    ready = 1;
    drain();
    chk("t2_empty_hold", data_o, mk(8'h20, 8'd1));
    clear();
    chk("t2_clr", 104'(ovf_o), 104'(0));
    // 3: short frame then -128 frame
    frame(5, 5, 8'h40, 8'd1, 0);
    q.push_back(mk(8'h80, 8'd0));
    frame(13, 13, 8'h80, 8'd0, 0);
    chk("t3_err", 104'(err_o), 104'(1));
    drain();
    clear();
    chk("t3_clr", 104'(err_o), 104'(0));
    // 4: long frame absorbed by DROP
    frame(16, 16, 8'h50, 8'd1, 0);
    chk("t4_err", 104'(err_o), 104'(1));
    chk("t4_noout", 104'(valid_o), 104'(0));
    q.push_back(mk(8'h60, 8'd3));
    frame(13, 13, 8'h60, 8'd3, 0);
    drain();
    clear();
    chk("t4_clr", 104'(err_o), 104'(0));
    // 5: full FIFO, pop and push on the same edge
    ready = 0;
    q.push_back(mk(8'h70, 8'd1));
    q.push_back(mk(8'h90, 8'd2));
    q.push_back(mk(8'hA5, 8'd1));
    frame(13, 13, 8'h70, 8'd1, 0);
    frame(13, 13, 8'h90, 8'd2, 0);
    frame(13, 13, 8'hA5, 8'd1, 1);
    chk("t5_ovf", 104'(ovf_o), 104'(0));
    chk("t5_head", data_o, mk(8'h90, 8'd2));
    drain();
    // 6: enable gap mid-frame
    q.push_back(mk(8'd1, 8'd1));
    frame(6, 0, 8'd1, 8'd1, 0);
    en = 0;
    valid = 1;
    data = 8'hEE;
    last = 1;
    repeat (4) tick();
    en = 1;
    frame(7, 7, 8'd7, 8'd1, 0);
    chk("t6_valid", 104'(valid_o), 104'(1));
    chk("t6_err", 104'(err_o), 104'(0));
    drain();
    // async reset mid-frame with a vector waiting
    ready = 0;
    frame(13, 13, 8'hA0, 8'd1, 0);
    frame(5, 0, 8'hB0, 8'd1, 0);
    chk("t6_prerst", 104'(valid_o), 104'(1));
    #3;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", 104'(valid_o), 104'(0));
    chk("t6_rst_data", data_o, 104'(0));
    @(posedge clk); #1;
    rst_n = 1;
    ready = 1;
    q.push_back(mk(8'hC0, 8'd1));
    frame(13, 13, 8'hC0, 8'd1, 0);
    chk("t6_after_err", 104'(err_o), 104'(0));
    drain();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
